// File: rtl/csr_reg.sv
// Single RISC-V Zicsr control/status register at a fixed address, with a peripheral side-effect write port.
// Define CSR_WMASK_EN to add the WriteMask parameter that makes unmasked bits read-only to CSR instructions.
module csr_reg #(
  parameter int unsigned          CsrWidth   = 32,
  parameter logic [11:0]          Addr       = 12'h000,
  parameter logic [CsrWidth-1:0]  ResetValue = '0
`ifdef CSR_WMASK_EN
  ,
  parameter logic [CsrWidth-1:0]  WriteMask  = '1
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                csr_enable,
  input  logic [11:0]         csr_addr,
  input  logic [2:0]          csr_op,
  input  logic [4:0]          rs1_zimm,
  input  logic [31:0]         rs1_data,
  input  logic [CsrWidth-1:0] ext_data,
  input  logic                ext_write_enable,
  output logic [CsrWidth-1:0] data,
  output logic [31:0]         direct_out,
  output logic [31:0]         out
);

  logic                sel;
  logic [31:0]         op_full;
  logic [CsrWidth-1:0] op_val;
  logic [CsrWidth-1:0] csr_next;
  logic [CsrWidth-1:0] csr_wdata;
  logic                csr_write;
  logic [31:0]         data_ext;

  assign sel     = csr_enable && (csr_addr == Addr);
  assign op_full = csr_op[2] ? {27'b0, rs1_zimm} : rs1_data;
  assign op_val  = op_full[CsrWidth-1:0];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    csr_write = 1'b0;
    csr_next  = data;
    if (sel) begin
      case (csr_op)
        3'b001, 3'b101: begin
          csr_write = 1'b1;
          csr_next  = op_val;
        end
        3'b010, 3'b110: begin
          csr_write = (rs1_zimm != 5'd0);
          csr_next  = data | op_val;
        end
        3'b011, 3'b111: begin
          csr_write = (rs1_zimm != 5'd0);
          csr_next  = data & ~op_val;
        end
        default: ;
      endcase
    end
  end

`ifdef CSR_WMASK_EN
  // Only software-writable bits take the instruction result; the rest keep their stored value.
  assign csr_wdata = (csr_next & WriteMask) | (data & ~WriteMask);
`else
  assign csr_wdata = csr_next;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data <= ResetValue;
    end else if (ext_write_enable) begin
      data <= ext_data;
    end else if (csr_write) begin
      data <= csr_wdata;
    end
  end

  // Zero-extend without a replication count, which would be zero-width when CsrWidth is 32.
  always_comb begin
    data_ext                 = '0;
    data_ext[CsrWidth-1:0]   = data;
  end

  assign direct_out = data_ext;
  assign out        = sel ? data_ext : 32'h0;

endmodule

// File: tb/tb_csr_reg.sv
// Randomized self-checking bench for csr_reg: a 32-bit and an 8-bit instance share the CSR bus.
// With CSR_WMASK_EN defined, a third instance with WriteMask 32'h0F is checked as well.
module tb_csr_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_enable;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [4:0]  rs1_zimm;
  logic [31:0] rs1_data;
  logic [31:0] ext_data32;
  logic        ext_write_enable;

  logic [31:0] d32, dir32, out32;
  logic [7:0]  d8;
  logic [31:0] dir8, out8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m32;
  logic [31:0] m8;

  always #5 clk = ~clk;

  csr_reg #(.CsrWidth(32), .Addr(12'h400), .ResetValue(32'h5)) dut32 (
    .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
    .csr_op(csr_op), .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
    .ext_data(ext_data32), .ext_write_enable(ext_write_enable),
    .data(d32), .direct_out(dir32), .out(out32)
  );

  csr_reg #(.CsrWidth(8), .Addr(12'h400), .ResetValue(8'hA5)) dut8 (
    .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
    .csr_op(csr_op), .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
    .ext_data(ext_data32[7:0]), .ext_write_enable(ext_write_enable),
    .data(d8), .direct_out(dir8), .out(out8)
  );

`ifdef CSR_WMASK_EN
  logic [31:0] dm, dirm, outm;
  logic [31:0] mm;
  csr_reg #(.CsrWidth(32), .Addr(12'h400), .ResetValue(32'h0), .WriteMask(32'h0F)) dutm (
    .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
    .csr_op(csr_op), .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
    .ext_data(ext_data32), .ext_write_enable(ext_write_enable),
    .data(dm), .direct_out(dirm), .out(outm)
  );
`endif

  // Reference: value after the coming edge, from the architectural rules of the current bus inputs.
  function automatic logic [31:0] model_next(input logic [31:0] old, input int w,
                                             input logic [31:0] wm, input logic [31:0] rv);
    logic [31:0] msk, v, n;
    msk = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    if (!reset) return rv & msk;
    if (ext_write_enable) return ext_data32 & msk;
    if (!(csr_enable && csr_addr == 12'h400)) return old;
    v = (csr_op[2] ? {27'b0, rs1_zimm} : rs1_data) & msk;
    case (csr_op[1:0])
      2'b01:   n = v;
      2'b10:   n = old | v;
      2'b11:   n = old & ~v;
      default: return old;
    endcase
    if (csr_op[1:0] != 2'b01 && rs1_zimm == 5'd0) return old;
    return ((n & wm) | (old & ~wm)) & msk;
  endfunction

  task automatic step(input logic en, input logic [11:0] addr, input logic [2:0] op,
                      input logic [4:0] zimm, input logic [31:0] rs1,
                      input logic ewe, input logic [31:0] ed, input logic rst, input string name);
    logic [31:0] exp, n32, n8;
`ifdef CSR_WMASK_EN
    logic [31:0] nm;
`endif
    @(negedge clk);
    csr_enable = en; csr_addr = addr; csr_op = op; rs1_zimm = zimm;
    rs1_data = rs1; ext_write_enable = ewe; ext_data32 = ed; reset = rst;
    #1;
    exp = (en && addr == 12'h400) ? m32 : 32'h0;
    n_checks++;
    if (out32 !== exp) begin
      n_fail++; $display("FAIL %s out32: got %h expected %h", name, out32, exp);
    end
    exp = (en && addr == 12'h400) ? m8 : 32'h0;
    n_checks++;
    if (out8 !== exp) begin
      n_fail++; $display("FAIL %s out8: got %h expected %h", name, out8, exp);
    end
    n32 = model_next(m32, 32, 32'hFFFF_FFFF, 32'h5);
    n8  = model_next(m8, 8, 32'hFFFF_FFFF, 32'hA5);
`ifdef CSR_WMASK_EN
    exp = (en && addr == 12'h400) ? mm : 32'h0;
    n_checks++;
    if (outm !== exp) begin
      n_fail++; $display("FAIL %s outm: got %h expected %h", name, outm, exp);
    end
    nm = model_next(mm, 32, 32'h0F, 32'h0);
`endif
    @(posedge clk);
    #1;
    m32 = n32; m8 = n8;
    n_checks++;
    if (d32 !== m32 || dir32 !== m32) begin
      n_fail++; $display("FAIL %s data32: got %h/%h expected %h", name, d32, dir32, m32);
    end
    n_checks++;
    if (d8 !== m8[7:0] || dir8 !== m8) begin
      n_fail++; $display("FAIL %s data8: got %h/%h expected %h", name, d8, dir8, m8);
    end
`ifdef CSR_WMASK_EN
    mm = nm;
    n_checks++;
    if (dm !== mm || dirm !== mm) begin
      n_fail++; $display("FAIL %s datam: got %h/%h expected %h", name, dm, dirm, mm);
    end
`endif
  endtask

  task automatic test_reset();
    step(1'b0, 12'h400, 3'b001, 5'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, "reset");
    n_checks++;
    if (d32 !== 32'h5 || dir32 !== 32'h5 || out32 !== 32'h0) begin
      n_fail++; $display("FAIL reset_value: got %h/%h/%h expected 5/5/0", d32, dir32, out32);
    end
    step(1'b1, 12'h400, 3'b000, 5'd7, 32'h1, 1'b0, 32'h0, 1'b1, "nop_000");
    step(1'b1, 12'h400, 3'b100, 5'd7, 32'h1, 1'b0, 32'h0, 1'b1, "nop_100");
  endtask

  task automatic test_rw();
    step(1'b1, 12'h400, 3'b001, 5'd3, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, "rw");
    n_checks++;
    if (d32 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rw_value: got %h expected deadbeef", d32);
    end
    step(1'b1, 12'h401, 3'b001, 5'd3, 32'h1234_5678, 1'b0, 32'h0, 1'b1, "rw_other_addr");
    step(1'b1, 12'h400, 3'b101, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, "rwi_zero");
  endtask

  task automatic test_set_clear();
    step(1'b1, 12'h400, 3'b001, 5'd1, 32'h0000_00F0, 1'b0, 32'h0, 1'b1, "rw_f0");
    step(1'b1, 12'h400, 3'b110, 5'h0F, 32'h0, 1'b0, 32'h0, 1'b1, "rsi");
    n_checks++;
    if (d32 !== 32'h0000_00FF) begin
      n_fail++; $display("FAIL rsi_value: got %h expected 000000ff", d32);
    end
    step(1'b1, 12'h400, 3'b011, 5'd2, 32'h0000_0003, 1'b0, 32'h0, 1'b1, "rc");
    n_checks++;
    if (d32 !== 32'h0000_00FC) begin
      n_fail++; $display("FAIL rc_value: got %h expected 000000fc", d32);
    end
    step(1'b1, 12'h400, 3'b010, 5'd0, 32'h0000_FFFF, 1'b0, 32'h0, 1'b1, "rs_x0");
    step(1'b1, 12'h400, 3'b011, 5'd0, 32'h0000_FFFF, 1'b0, 32'h0, 1'b1, "rc_x0");
    step(1'b1, 12'h400, 3'b111, 5'h04, 32'h0, 1'b0, 32'h0, 1'b1, "rci");
  endtask

  task automatic test_width();
    step(1'b1, 12'h400, 3'b001, 5'd1, 32'h0000_1234, 1'b0, 32'h0, 1'b1, "width");
    n_checks++;
    if (d8 !== 8'h34 || dir8 !== 32'h34) begin
      n_fail++; $display("FAIL width_value: got %h/%h expected 34/00000034", d8, dir8);
    end
  endtask

  task automatic test_collision();
    step(1'b1, 12'h400, 3'b001, 5'd1, 32'h0000_AAAA, 1'b1, 32'h1, 1'b1, "ext_wins");
    n_checks++;
    if (d32 !== 32'h1) begin
      n_fail++; $display("FAIL ext_wins_value: got %h expected 00000001", d32);
    end
    step(1'b1, 12'h400, 3'b001, 5'd1, 32'h0000_AAAA, 1'b1, 32'h77, 1'b0, "reset_wins");
  endtask

  task automatic test_back_to_back();
    step(1'b1, 12'h400, 3'b001, 5'd1, 32'h0000_0010, 1'b0, 32'h0, 1'b1, "b2b_rw");
    step(1'b1, 12'h400, 3'b010, 5'd1, 32'h0000_0001, 1'b0, 32'h0, 1'b1, "b2b_rs");
    step(1'b1, 12'h400, 3'b011, 5'd1, 32'h0000_0010, 1'b0, 32'h0, 1'b1, "b2b_rc");
  endtask

`ifdef CSR_WMASK_EN
  task automatic test_wmask();
    step(1'b1, 12'h400, 3'b001, 5'd1, 32'h0, 1'b1, 32'h0, 1'b1, "mask_clear");
    step(1'b1, 12'h400, 3'b001, 5'd1, 32'hFF, 1'b0, 32'h0, 1'b1, "mask_rw");
    n_checks++;
    if (dm !== 32'h0F) begin
      n_fail++; $display("FAIL mask_rw_value: got %h expected 0000000f", dm);
    end
    step(1'b0, 12'h400, 3'b000, 5'd0, 32'h0, 1'b1, 32'hF0, 1'b1, "mask_ext");
    n_checks++;
    if (dm !== 32'hF0) begin
      n_fail++; $display("FAIL mask_ext_value: got %h expected 000000f0", dm);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [4:0] z;
      z = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step(($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0) ? 12'h401 : 12'h400,
           3'($urandom), z, $urandom,
           ($urandom_range(0, 9) == 0), $urandom,
           ($urandom_range(0, 19) != 0), "random");
    end
  endtask

  initial begin
    reset = 1'b0; csr_enable = 1'b0; csr_addr = 12'h0; csr_op = 3'b0;
    rs1_zimm = 5'd0; rs1_data = 32'h0; ext_data32 = 32'h0; ext_write_enable = 1'b0;
    m32 = 32'h0; m8 = 32'h0;
`ifdef CSR_WMASK_EN
    mm = 32'h0;
`endif
    test_reset();
    test_rw();
    test_set_clear();
    test_width();
    test_collision();
    test_back_to_back();
`ifdef CSR_WMASK_EN
    test_wmask();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
